// File: rtl/pipelined_signed_adder.sv
// Purpose : two's-complement adder/subtractor split into STAGES carry-registered chunks, optional saturation.
// Latency : STAGES cycles from accepted operands to out_valid_o; one result per cycle sustained.
// Backpressure: whole pipeline freezes when out_valid_o=1 and out_ready_i=0; in_ready_o mirrors the enable.
module pipelined_signed_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    // Guarded so an illegal STAGES value reaches the check below instead of dividing by zero.
    localparam int STG_SAFE = (STAGES > 0) ? STAGES : 1;
    localparam int CW       = WIDTH / STG_SAFE;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH < 4) || (WIDTH > 64) || (STAGES < 1) || (STAGES > WIDTH) ||
        ((WIDTH % STG_SAFE) != 0)) begin : g_param_check
        $error("pipelined_signed_adder: WIDTH must be 4..64 and a multiple of STAGES");
    end

    // ------------------------------------------------------------------
    // Global pipeline enable: every stage moves together, so a stalled
    // output register freezes the whole pipe and the input handshake.
    // ------------------------------------------------------------------
    logic en;
    logic out_vld_q;

    assign en          = ~out_vld_q | out_ready_i;
    assign in_ready_o  = en;
    assign out_valid_o = out_vld_q;

    // Subtraction is folded in up front: A - B == A + ~B + 1, cin ignored.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = b_i ^ {WIDTH{sub_i}};
    assign c_eff = sub_i | cin_i;

    // ------------------------------------------------------------------
    // Intermediate stages 0 .. STAGES-2. Stage k adds chunk k and hands
    // the untouched upper operand bits, the finished low sum bits and the
    // chunk carry to stage k+1. Carry chains are at most CW bits long.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_mid
        localparam int AW = WIDTH - k * CW;    // operand bits not yet added entering this stage
        localparam int LW = (k + 1) * CW;      // sum bits complete after this stage

        logic [AW-1:0] op_a;
        logic [AW-1:0] op_b;
        logic          op_c;
        logic          op_v;
        logic [CW:0]   chunk;
        logic [LW-1:0] lo_d;

        logic             vld_q;
        logic             c_q;
        logic [AW-CW-1:0] hi_a_q;
        logic [AW-CW-1:0] hi_b_q;
        logic [LW-1:0]    lo_q;

        if (k == 0) begin : g_from_ports
            assign op_a = a_i;
            assign op_b = b_eff;
            assign op_c = c_eff;
            assign op_v = in_valid_i;
            assign lo_d = chunk[CW-1:0];
        end else begin : g_from_prev
            assign op_a = g_mid[k-1].hi_a_q;
            assign op_b = g_mid[k-1].hi_b_q;
            assign op_c = g_mid[k-1].c_q;
            assign op_v = g_mid[k-1].vld_q;
            assign lo_d = {chunk[CW-1:0], g_mid[k-1].lo_q};
        end

        assign chunk = {1'b0, op_a[CW-1:0]} + {1'b0, op_b[CW-1:0]} + {{CW{1'b0}}, op_c};

        // Stage valid bit: cleared by reset, otherwise follows the upstream valid when enabled.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
            end else if (en) begin
                vld_q <= op_v;
            end
        end

        // Stage data: no reset needed, contents only matter while vld_q is set.
        always_ff @(posedge clk_i) begin
            if (en) begin
                c_q    <= chunk[CW];
                hi_a_q <= op_a[AW-1:CW];
                hi_b_q <= op_b[AW-1:CW];
                lo_q   <= lo_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Final stage: adds the top chunk, derives carry-out and signed
    // overflow, applies optional saturation and loads the output register.
    // With STAGES=1 this is the only stage and reads the ports directly.
    // ------------------------------------------------------------------
    logic [CW-1:0]    fin_a;
    logic [CW-1:0]    fin_b;
    logic             fin_c;
    logic             fin_v;
    logic [CW:0]      fin_chunk;
    logic [WIDTH-1:0] raw_sum;

    if (STAGES == 1) begin : g_fin_ports
        assign fin_a   = a_i;
        assign fin_b   = b_eff;
        assign fin_c   = c_eff;
        assign fin_v   = in_valid_i;
        assign raw_sum = fin_chunk[CW-1:0];
    end else begin : g_fin_prev
        assign fin_a   = g_mid[STAGES-2].hi_a_q;
        assign fin_b   = g_mid[STAGES-2].hi_b_q;
        assign fin_c   = g_mid[STAGES-2].c_q;
        assign fin_v   = g_mid[STAGES-2].vld_q;
        assign raw_sum = {fin_chunk[CW-1:0], g_mid[STAGES-2].lo_q};
    end

    assign fin_chunk = {1'b0, fin_a} + {1'b0, fin_b} + {{CW{1'b0}}, fin_c};

    logic             cout_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Carry-in to the MSB differs from carry-out exactly when both operand
    // signs agree and the result sign disagrees; the sign form avoids
    // splitting the top chunk when CW is a single bit.
    assign cout_d = fin_chunk[CW];
    assign ovf_d  = (fin_a[CW-1] ~^ fin_b[CW-1]) & (fin_chunk[CW-1] ^ fin_a[CW-1]);

    // Result select: clamp toward the common operand sign on overflow when saturating.
    always_comb begin
        sum_d = raw_sum;
        if (SAT && ovf_d) begin
            sum_d = fin_a[CW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Output register: reset to zero, frozen while stalled, loaded only by valid results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (en) begin
            out_vld_q <= fin_v;
            if (fin_v) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_pipelined_signed_adder.sv
// Bench for pipelined_signed_adder, WIDTH=16 STAGES=4, wrap and saturate instances side by side.
// Directed vectors with hand-computed results, a 20-item stream with a 3-cycle stall,
// random bubbles with latency tracking, and reset flushing in-flight work.
module tb_pipelined_signed_adder;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         sub_i;
    logic         out_ready_i;

    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [W-1:0] s_sum;
    logic         s_cout;
    logic         s_ovf;

    always #5 clk_i = ~clk_i;

    pipelined_signed_adder #(.WIDTH(W), .STAGES(4), .SAT(1'b0)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o)
    );

    pipelined_signed_adder #(.WIDTH(W), .STAGES(4), .SAT(1'b1)) dut_sat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (s_in_ready),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .sub_i       (sub_i),
        .out_valid_o (s_out_valid),
        .out_ready_i (out_ready_i),
        .sum_o       (s_sum),
        .cout_o      (s_cout),
        .ovf_o       (s_ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [W-1:0] ssum;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [W-1:0] ssum;
    } vec_t;

    exp_t q[$];
    exp_t cur_exp;
    vec_t dv[11];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit lat_en = 1'b1;
    int n_out = 0;
    int first_out = 0;
    int last_out = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: integer arithmetic for the signed value, unsigned 17-bit sum for carry-out.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        int           sa;
        int           sb;
        int           s;
        logic [W-1:0] bb;
        logic [W:0]   full;
        sa   = $signed(a);
        sb   = $signed(b);
        s    = sub ? (sa - sb) : (sa + sb + int'(cin));
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (s > 32767) || (s < -32768);
        e.ssum = (s > 32767) ? 16'h7FFF : ((s < -32768) ? 16'h8000 : e.sum);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.sum  = v.sum;
        e.cout = v.cout;
        e.ovf  = v.ovf;
        e.ssum = v.ssum;
        e.cyc  = 0;
        return e;
    endfunction

    always @(posedge clk_i) cyc++;

    // Scoreboard, sampled mid-cycle: pop on output handshake, push on input handshake.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            q.delete();
        end else begin
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    check("unexpected_out", out_valid_o, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("sum", sum_o, e.sum);
                    check("cout", cout_o, e.cout);
                    check("ovf", ovf_o, e.ovf);
                    check("sat_valid", s_out_valid, 1'b1);
                    check("sat_sum", s_sum, e.ssum);
                    check("sat_flags", {s_cout, s_ovf}, {e.cout, e.ovf});
                    if (lat_en) check("latency", cyc - e.cyc, 4);
                    n_out++;
                    if (n_out == 1) first_out = cyc;
                    last_out = cyc;
                end
            end
            if (in_valid_i && in_ready_o) begin
                cur_exp.cyc = cyc;
                q.push_back(cur_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
        int guard;
        bit acc;
        guard      = 0;
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        cin_i      = cin;
        sub_i      = sub;
        cur_exp    = e;
        do begin
            #1;
            acc = in_ready_o;
            step();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("accept_timeout", in_ready_o, 1'b1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        in_valid_i = 1'b0;
        while (q.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        check(tag, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held_sum;
        logic         held_vld;
        bit           seen;

        //             a        b        cin   sub   sum      cout  ovf   sat sum
        dv[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
        dv[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'h8000};
        dv[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        dv[3]  = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0, 16'h1236};
        dv[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000};
        dv[5]  = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0002};
        dv[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};
        dv[7]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 16'h0101};
        dv[8]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        dv[9]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE};
        dv[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 16'h7FFF};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        cin_i       = 1'b0;
        sub_i       = 1'b0;
        out_ready_i = 1'b1;
        cur_exp     = '{default: 0};
        repeat (2) step();
        rst_i = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_sum", sum_o, 16'h0000);
        check("rst_cout", cout_o, 1'b0);
        check("rst_ovf", ovf_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_sat_in_ready", s_in_ready, 1'b1);

        // Directed vectors, back to back, latency 4 each
        lat_en = 1'b1;
        n_out  = 0;
        for (int i = 0; i < 11; i++) begin
            send(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, from_vec(dv[i]));
        end
        drain("directed_drain");
        check("directed_count", n_out, 11);

        // 20-item stream with a 3-cycle output stall in the middle
        lat_en = 1'b0;
        n_out  = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    logic         rc;
                    logic         rs;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom);
                    rs = 1'($urandom);
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
                end
            end
            begin
                repeat (8) step();
                out_ready_i = 1'b0;
                held_sum    = sum_o;
                held_vld    = out_valid_o;
                check("stall_valid_before", held_vld, 1'b1);
                for (int s = 0; s < 3; s++) begin
                    #1;
                    check("stall_in_ready", in_ready_o, 1'b0);
                    step();
                    check("stall_hold_sum", sum_o, held_sum);
                    check("stall_hold_valid", out_valid_o, held_vld);
                end
                out_ready_i = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_count", n_out, 20);
        check("stall_span", last_out - first_out, 22);

        // Random input bubbles, no backpressure
        lat_en = 1'b1;
        n_out  = 0;
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            idle($urandom_range(0, 2));
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drain("bubble_drain");
        check("bubble_count", n_out, 20);

        // Reset with three operand sets in flight
        n_out = 0;
        for (int i = 0; i < 3; i++) begin
            send(dv[i].a, dv[i].b, dv[i].cin, dv[i].sub, from_vec(dv[i]));
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("flush_out_valid", out_valid_o, 1'b0);
        check("flush_sum", sum_o, 16'h0000);
        check("flush_in_ready", in_ready_o, 1'b1);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (out_valid_o || s_out_valid) seen = 1'b1;
        end
        check("flush_no_stale", seen, 1'b0);
        check("flush_count", n_out, 0);

        // Pipeline still usable after the flush
        send(dv[3].a, dv[3].b, dv[3].cin, dv[3].sub, from_vec(dv[3]));
        drain("post_flush_drain");
        check("post_flush_count", n_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
